// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with a 2-flop synchronizer, mid-bit sampling and a sticky byte-ready flag.
// Latency: rdy rises about 2 + BAUD_DIV/2 + 9*BAUD_DIV clocks after the start-bit falling edge on rx.
// Backpressure: none; an unacknowledged byte is overwritten by the next frame (no overrun flag).
//
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset
//   rx       serial line, idle high, LSB first, asynchronous to clk
//   clr_rdy  consumer acknowledge; clears rdy and frm_err
//   rx_data  last received byte, valid while rdy=1
//   rdy      byte-available flag, held until cleared
//   frm_err  stop bit of the last frame was sampled low; qualifies rdy
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    // The counter runs value..0 inclusive, so a reload of BAUD_DIV-1 gives
    // exactly BAUD_DIV clocks between consecutive sample points.
    localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
    localparam logic [11:0] RELOAD   = 12'(BAUD_DIV - 1);

    typedef enum logic {
        IDLE      = 1'b0,
        RECEIVING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  shift_reg_q, shift_reg_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        shift;

    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        rdy_d       = rdy_q;
        frm_err_d   = frm_err_q;
        shift       = 1'b0;

        // Acknowledge is applied first so that a set later in this block wins.
        if (clr_rdy) begin
            rdy_d     = 1'b0;
            frm_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Counter holds here; it only loads on start detection.
                if (!rx_sync_q) begin
                    state_d    = RECEIVING;
                    baud_cnt_d = HALF_BIT;
                    bit_cnt_d  = 4'd0;
                    rdy_d      = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            RECEIVING: begin
                shift = (baud_cnt_q == 12'd0);
                if (shift) begin
                    baud_cnt_d  = RELOAD;
                    shift_reg_d = {rx_sync_q, shift_reg_q[8:1]};
                    bit_cnt_d   = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd0 && rx_sync_q) begin
                        // Line was high again at mid start bit: glitch, not a frame.
                        state_d = IDLE;
                    end else if (bit_cnt_q == 4'd9) begin
                        // Stop-bit sample; start bit has fallen off the bottom,
                        // leaving data in [7:0] and the stop bit in [8].
                        state_d   = IDLE;
                        rdy_d     = 1'b1;
                        frm_err_d = ~rx_sync_q;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            baud_cnt_q  <= 12'd0;
            bit_cnt_q   <= 4'd0;
            shift_reg_q <= 9'h1FF;
            rdy_q       <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            rdy_q       <= rdy_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign rx_data = shift_reg_q[7:0];
    assign rdy     = rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: randomized self-checking bench for uart_rx against a frame-level reference model.
// Latency: each expected byte must appear within a small window around start + half bit + 9 bits.
// Backpressure: none; the bench drives rx and clr_rdy freely.
module tb_uart_rx;

    localparam int B   = 32;
    localparam int H   = B / 2;
    // Start edge -> rdy seen: 2 sync stages, 1 detect, half bit, 9 full bits, 1 sample.
    localparam int LAT = H + 9 * B + 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    uart_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: every frame that should complete is queued with its
    // byte, expected frame-error flag and start time (t0 < 0: no latency check).
    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         t0;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_evt   = 0;
    int   n_exp   = 0;
    int   lat     = 0;
    logic rdy_prev = 1'b0;

    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
            n_evt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.d});
                chk("frm_err", {31'd0, frm_err}, {31'd0, mon_e.fe});
                if (mon_e.t0 >= 0) begin
                    lat = cyc - mon_e.t0;
                    chk("latency_window", {31'd0, (lat >= LAT - 2 && lat <= LAT + 1)}, 32'd1);
                end
            end
        end
        rdy_prev = rdy;
    end

    task automatic expect_byte(input logic [7:0] d, input logic fe, input int t0);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.t0 = t0;
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame, B clocks per bit; leaves rx at the stop value
    // unless release_line is set.
    task automatic send(input logic [7:0] d, input logic stop, input bit expect_evt,
                        input bit release_line);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        @(negedge clk);
        if (expect_evt) expect_byte(d, ~stop, cyc);
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (B) @(negedge clk);
        end
        if (release_line) rx = 1'b1;
    endtask

    task automatic pulse_clr_and_check();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        chk("clr_rdy_rdy", {31'd0, rdy}, 32'd0);
        chk("clr_rdy_frm_err", {31'd0, frm_err}, 32'd0);
    endtask

    initial begin
        int n_before;
        logic [7:0] d;
        logic stop;

        // Reset and idle release.
        idle(3);
        chk("reset_rdy", {31'd0, rdy}, 32'd0);
        chk("reset_frm_err", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        idle(2 * B);
        chk("post_reset_rdy", {31'd0, rdy}, 32'd0);

        // Basic frame; rdy must be held without an acknowledge.
        send(8'hA5, 1'b1, 1'b1, 1'b1);
        idle(4);
        chk("rdy_held", {31'd0, rdy}, 32'd1);
        chk("rx_data_held", {24'd0, rx_data}, 32'h0000_00A5);
        pulse_clr_and_check();
        idle(B);

        // Back-to-back frames with no idle between stop and next start.
        send(8'h00, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b1, 1'b1);
        send(8'h5A, 1'b1, 1'b1, 1'b1);
        pulse_clr_and_check();
        idle(B);

        // Short low glitch: must be rejected at the mid start-bit sample.
        n_before = n_evt;
        @(negedge clk);
        rx = 1'b0;
        idle(6);
        rx = 1'b1;
        idle(12 * B);
        chk("false_start_rdy", {31'd0, rdy}, 32'd0);
        chk("false_start_events", n_evt, n_before);

        // Framing error.
        send(8'h3C, 1'b0, 1'b1, 1'b1);
        idle(8);
        pulse_clr_and_check();
        idle(B);

        // Acknowledge held across the set cycle: set must win for that cycle.
        clr_rdy = 1'b1;
        send(8'h96, 1'b1, 1'b1, 1'b1);
        clr_rdy = 1'b0;
        @(negedge clk);
        chk("held_clr_rdy", {31'd0, rdy}, 32'd0);
        chk("held_clr_frm_err", {31'd0, frm_err}, 32'd0);
        idle(B);

        // Randomized frames, gaps and acknowledges.
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send(d, stop, 1'b1, 1'b1);
            if ($urandom_range(0, 1) == 1) pulse_clr_and_check();
            idle($urandom_range(4, 3 * B));
        end
        idle(B);

        // Break: line held low past the stop sample. The first frame reports
        // 00 with a framing error, reception restarts at once and the second
        // frame (all zeros) reports the same; the line is released shortly
        // after the second stop sample so the third restart is a false start.
        send(8'h00, 1'b0, 1'b1, 1'b0);
        expect_byte(8'h00, 1'b1, -1);
        idle(9 * B + H / 2);
        rx = 1'b1;
        idle(3 * B);
        chk("break_events_done", exp_q.size(), 32'd0);

        // Reset in the middle of a frame aborts it silently.
        @(negedge clk);
        rx = 1'b0;
        idle(B);
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0);
            idle(B);
        end
        rst_n = 1'b0;
        idle(2);
        rx = 1'b1;
        chk("mid_frame_reset_rdy", {31'd0, rdy}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(12 * B);
        chk("after_abort_rdy", {31'd0, rdy}, 32'd0);
        send(8'h81, 1'b1, 1'b1, 1'b1);
        idle(2 * B);

        chk("pending_expected", exp_q.size(), 32'd0);
        chk("event_count", n_evt, n_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
